// File: rtl/calc_rr_arbiter.sv
// Round-robin arbiter that shares one combinational calculator between two requesters.
// It latches the winner's operands, holds them for SETTLE cycles, then registers the result.
module calc_rr_arbiter #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_req,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_b0,
  input  logic [1:0]       i_sel0,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b1,
  input  logic [1:0]       i_sel1,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [1:0]       o_alu_sel,
  input  logic [WIDTH-1:0] i_alu_result,
  output logic [1:0]       o_grant,
  output logic [1:0]       o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_div0,
  output logic             o_busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               last, last_nxt;
  logic               winner;
  logic [WIDTH-1:0]   alu_a_nxt, alu_b_nxt, result_nxt;
  logic [1:0]         alu_sel_nxt, grant_nxt, done_nxt;
  logic               div0_nxt, busy_nxt;

  // State and all outputs are registered; last also identifies the current owner.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_sel <= '0;
      o_grant   <= '0;
      o_done    <= '0;
      o_result  <= '0;
      o_div0    <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      o_alu_a   <= alu_a_nxt;
      o_alu_b   <= alu_b_nxt;
      o_alu_sel <= alu_sel_nxt;
      o_grant   <= grant_nxt;
      o_done    <= done_nxt;
      o_result  <= result_nxt;
      o_div0    <= div0_nxt;
      o_busy    <= busy_nxt;
    end
  end

  // On contention the requester that did not win last time goes first.
  always_comb begin
    winner = (i_req == 2'b11) ? ~last : i_req[1];
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    last_nxt    = last;
    alu_a_nxt   = o_alu_a;
    alu_b_nxt   = o_alu_b;
    alu_sel_nxt = o_alu_sel;
    grant_nxt   = '0;
    done_nxt    = '0;
    result_nxt  = o_result;
    div0_nxt    = o_div0;

    unique case (state)
      IDLE: begin
        if (i_req != 2'b00) begin
          state_nxt   = EXEC;
          last_nxt    = winner;
          cnt_nxt     = CNT_W'(SETTLE - 1);
          grant_nxt   = winner ? 2'b10 : 2'b01;
          alu_a_nxt   = winner ? i_a1 : i_a0;
          alu_b_nxt   = winner ? i_b1 : i_b0;
          alu_sel_nxt = winner ? i_sel1 : i_sel0;
        end
      end
      EXEC: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt  = IDLE;
          result_nxt = i_alu_result;
          div0_nxt   = (o_alu_sel == 2'b11) && (o_alu_b == '0);
          done_nxt   = last ? 2'b10 : 2'b01;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == EXEC);
  end

endmodule

// File: tb/tb_calc_rr_arbiter.sv
// Directed bench for calc_rr_arbiter: one instance with SETTLE=1 and one with SETTLE=3,
// each driving its own copy of a behavioural calculator.
module tb_calc_rr_arbiter;

  localparam int unsigned W  = 4;
  localparam int unsigned S1 = 1;
  localparam int unsigned S3 = 3;

  logic         clk = 1'b0;
  logic         rst1, rst3;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   sel0, sel1;

  logic [W-1:0] alu_a1, alu_b1, res_in1, result1;
  logic [1:0]   alu_sel1, grant1, done1;
  logic         div01, busy1;
  logic [W-1:0] alu_a3, alu_b3, res_in3, result3;
  logic [1:0]   alu_sel3, grant3, done3;
  logic         div03, busy3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared calculator.
  function automatic logic [W-1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] sel);
    logic [2*W-1:0] p;
    case (sel)
      2'b00:   calc = a + b;
      2'b01:   calc = a - b;
      2'b10:   begin p = a * b; calc = p[W-1:0]; end
      default: calc = (b == '0) ? '0 : a / b;
    endcase
  endfunction

  assign res_in1 = calc(alu_a1, alu_b1, alu_sel1);
  assign res_in3 = calc(alu_a3, alu_b3, alu_sel3);

  calc_rr_arbiter #(.WIDTH(W), .SETTLE(S1)) dut1 (
    .i_clk(clk), .i_reset(rst1), .i_req(req),
    .i_a0(a0), .i_b0(b0), .i_sel0(sel0), .i_a1(a1), .i_b1(b1), .i_sel1(sel1),
    .o_alu_a(alu_a1), .o_alu_b(alu_b1), .o_alu_sel(alu_sel1), .i_alu_result(res_in1),
    .o_grant(grant1), .o_done(done1), .o_result(result1), .o_div0(div01), .o_busy(busy1)
  );

  calc_rr_arbiter #(.WIDTH(W), .SETTLE(S3)) dut3 (
    .i_clk(clk), .i_reset(rst3), .i_req(req),
    .i_a0(a0), .i_b0(b0), .i_sel0(sel0), .i_a1(a1), .i_b1(b1), .i_sel1(sel1),
    .o_alu_a(alu_a3), .o_alu_b(alu_b3), .o_alu_sel(alu_sel3), .i_alu_result(res_in3),
    .o_grant(grant3), .o_done(done3), .o_result(result3), .o_div0(div03), .o_busy(busy3)
  );

  // Legal SETTLE range is 1..15; anything else is undefined behaviour.
  initial begin
    if (S1 < 1 || S1 > 15 || S3 < 1 || S3 > 15) begin
      $display("FAIL settle_range S1=%0d S3=%0d required 1..15", S1, S3);
      $fatal(1, "SETTLE out of range");
    end
  end

  task automatic do_reset();
    req = 2'b00; a0 = '0; b0 = '0; sel0 = 2'b00; a1 = '0; b1 = '0; sel1 = 2'b00;
    rst1 = 1'b1; rst3 = 1'b1;
    repeat (2) @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant1, done1, result1, div01, busy1, alu_a1, alu_b1, alu_sel1} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_s1 got g=%b d=%b r=%0d z=%b busy=%b a=%0d b=%0d sel=%b want all 0",
               grant1, done1, result1, div01, busy1, alu_a1, alu_b1, alu_sel1);
    end
    checks++;
    if ({grant3, done3, result3, div03, busy3, alu_a3, alu_b3, alu_sel3} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_s3 got g=%b d=%b r=%0d busy=%b want all 0",
               grant3, done3, result3, busy3);
    end
  endtask

  task automatic test_single();
    do_reset();
    a0 = 4'd3; b0 = 4'd4; sel0 = 2'b00; req = 2'b01;
    @(negedge clk);
    checks++;
    if (grant1 !== 2'b01 || busy1 !== 1'b1 || done1 !== 2'b00 || alu_a1 !== 4'd3) begin
      failures++;
      $display("FAIL single_grant got g=%b busy=%b d=%b a=%0d want g=01 busy=1 d=00 a=3",
               grant1, busy1, done1, alu_a1);
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (done1 !== 2'b01 || result1 !== 4'd7 || div01 !== 1'b0 || grant1 !== 2'b00 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL single_done got d=%b r=%0d z=%b g=%b busy=%b want d=01 r=7 z=0 g=00 busy=0",
               done1, result1, div01, grant1, busy1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 2'b00 || result1 !== 4'd7) begin
      failures++;
      $display("FAIL single_hold got d=%b r=%0d want d=00 r=7", done1, result1);
    end
  endtask

  task automatic test_contention();
    logic [1:0]   exp_g [4];
    logic [W-1:0] exp_r [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    exp_r[0] = 4'd7;  exp_r[1] = 4'd15; exp_r[2] = 4'd7;  exp_r[3] = 4'd15;
    do_reset();
    a0 = 4'd9; b0 = 4'd2; sel0 = 2'b01;
    a1 = 4'd3; b1 = 4'd5; sel1 = 2'b10;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (grant1 !== exp_g[i] || done1 !== 2'b00) begin
        failures++;
        $display("FAIL contention_grant%0d got g=%b d=%b want g=%b d=00", i, grant1, done1, exp_g[i]);
      end
      @(negedge clk);
      checks++;
      if (done1 !== exp_g[i] || result1 !== exp_r[i] || grant1 !== 2'b00) begin
        failures++;
        $display("FAIL contention_done%0d got d=%b r=%0d g=%b want d=%b r=%0d g=00",
                 i, done1, result1, grant1, exp_g[i], exp_r[i]);
      end
    end
    req = 2'b00;
  endtask

  task automatic test_div0_wrap();
    do_reset();
    a1 = 4'd9; b1 = 4'd0; sel1 = 2'b11; req = 2'b10;
    @(negedge clk);
    checks++;
    if (grant1 !== 2'b10) begin
      failures++;
      $display("FAIL div0_grant got g=%b want 10", grant1);
    end
    a1 = 4'd15; b1 = 4'd1; sel1 = 2'b00; req = 2'b00;
    @(negedge clk);
    checks++;
    if (done1 !== 2'b10 || result1 !== 4'd0 || div01 !== 1'b1) begin
      failures++;
      $display("FAIL div0_done got d=%b r=%0d z=%b want d=10 r=0 z=1", done1, result1, div01);
    end
    req = 2'b10;
    @(negedge clk);
    checks++;
    if (grant1 !== 2'b10 || alu_a1 !== 4'd15) begin
      failures++;
      $display("FAIL wrap_grant got g=%b a=%0d want g=10 a=15", grant1, alu_a1);
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (done1 !== 2'b10 || result1 !== 4'd0 || div01 !== 1'b0) begin
      failures++;
      $display("FAIL wrap_done got d=%b r=%0d z=%b want d=10 r=0 z=0", done1, result1, div01);
    end
  endtask

  task automatic test_settle3_freeze();
    do_reset();
    a0 = 4'd6; b0 = 4'd2; sel0 = 2'b10; req = 2'b01;
    @(negedge clk);
    checks++;
    if (grant3 !== 2'b01 || alu_a3 !== 4'd6 || busy3 !== 1'b1) begin
      failures++;
      $display("FAIL s3_grant got g=%b a=%0d busy=%b want g=01 a=6 busy=1", grant3, alu_a3, busy3);
    end
    a0 = 4'd1; req = 2'b00;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++;
      if (done3 !== 2'b00 || alu_a3 !== 4'd6 || busy3 !== 1'b1) begin
        failures++;
        $display("FAIL s3_exec%0d got d=%b a=%0d busy=%b want d=00 a=6 busy=1", i, done3, alu_a3, busy3);
      end
    end
    @(negedge clk);
    checks++;
    if (done3 !== 2'b01 || result3 !== 4'd12 || alu_a3 !== 4'd6 || busy3 !== 1'b0) begin
      failures++;
      $display("FAIL s3_done got d=%b r=%0d a=%0d busy=%b want d=01 r=12 a=6 busy=0",
               done3, result3, alu_a3, busy3);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a0 = 4'd6; b0 = 4'd2; sel0 = 2'b10; req = 2'b01;
    @(negedge clk);
    checks++;
    if (grant3 !== 2'b01) begin
      failures++;
      $display("FAIL midrst_grant got g=%b want 01", grant3);
    end
    req = 2'b00;
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    checks++;
    if ({grant3, done3, result3, div03, busy3, alu_a3, alu_b3, alu_sel3} !== '0) begin
      failures++;
      $display("FAIL midrst_clear got g=%b d=%b r=%0d busy=%b a=%0d b=%0d sel=%b want all 0",
               grant3, done3, result3, busy3, alu_a3, alu_b3, alu_sel3);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done3 !== 2'b00) begin
        failures++;
        $display("FAIL midrst_nodone%0d got d=%b want 00", i, done3);
      end
    end
    a0 = 4'd1; b0 = 4'd1; sel0 = 2'b00; a1 = 4'd2; b1 = 4'd2; sel1 = 2'b00; req = 2'b11;
    @(negedge clk);
    checks++;
    if (grant3 !== 2'b01) begin
      failures++;
      $display("FAIL midrst_priority got g=%b want 01", grant3);
    end
    req = 2'b00;
  endtask

  task automatic test_back_to_back();
    do_reset();
    a0 = 4'd2; b0 = 4'd3; sel0 = 2'b00; req = 2'b01;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      checks++;
      if ((grant1 !== ((n % 2 == 1) ? 2'b01 : 2'b00)) ||
          (done1 !== ((n % 2 == 0) ? 2'b01 : 2'b00)) ||
          ((n % 2 == 0) && result1 !== 4'd5)) begin
        failures++;
        $display("FAIL b2b_cycle%0d got g=%b d=%b r=%0d want g=%b d=%b r=5", n, grant1, done1, result1,
                 (n % 2 == 1) ? 2'b01 : 2'b00, (n % 2 == 0) ? 2'b01 : 2'b00);
      end
      checks++;
      if ((grant1 & done1) !== 2'b00 && (grant1 != 2'b00 && done1 != 2'b00)) begin
        failures++;
        $display("FAIL b2b_overlap%0d got g=%b d=%b want no overlap", n, grant1, done1);
      end
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_div0_wrap();
    test_settle3_freeze();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_rr_arbiter.md
# calc_rr_arbiter

Round-robin arbiter and sequencer that shares one 4-bit combinational calculator datapath between two requesters. It owns the calculator's operand and operator inputs, latches the winning requester's operands, and holds them stable for a programmable settle time. It then registers the calculator result and returns it with a one-cycle completion pulse. It sits between the two requesters (e.g. key-entry logic and a test sequencer) and the shared calculator, whose result then feeds the BCD/FND display path.

## Interface
- `WIDTH`, default 4: operand and result width; must match the calculator.
- `SETTLE`, default 1: cycles the operands are held before the result is captured; legal range 1..15.

- `i_clk`, in, 1: clock.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_req`, in, 2: request per requester; bit n belongs to requester n.
- `i_a0`, `i_b0`, in, WIDTH each: requester 0 operands.
- `i_sel0`, in, 2: requester 0 operator; 00 add, 01 sub, 10 mul, 11 div.
- `i_a1`, `i_b1`, in, WIDTH each: requester 1 operands.
- `i_sel1`, in, 2: requester 1 operator.
- `o_alu_a`, `o_alu_b`, out, WIDTH each: registered operands driven to the calculator.
- `o_alu_sel`, out, 2: registered operator driven to the calculator.
- `i_alu_result`, in, WIDTH: calculator result.
- `o_grant`, out, 2: one-hot, one-cycle pulse that marks the winner.
- `o_done`, out, 2: one-hot, one-cycle pulse that marks the owner of `o_result`.
- `o_result`, out, WIDTH: registered result; holds its value until the next capture.
- `o_div0`, out, 1: registered with `o_result`; 1 when the captured op was a divide with B==0.
- `o_busy`, out, 1: high while the FSM is in EXEC.

## Operation
- **FSM states.** IDLE and EXEC.
- **IDLE.**
  - At each edge, `i_req` is sampled.
  - If no request is pending, the FSM stays in IDLE.
  - If exactly one request is pending, that requester wins.
  - If both are pending, the requester other than `r_last` wins.
- **Grant edge (IDLE→EXEC).**
  - The winner's A, B and sel are latched into `o_alu_a`, `o_alu_b` and `o_alu_sel`.
  - `o_grant[winner]` is set for one cycle.
  - `r_last` is set to the winner.
  - The settle counter is loaded with SETTLE-1.
- **EXEC.**
  - Requester inputs are ignored; the operands stay frozen.
  - If the counter is non-zero, it decrements.
  - If the counter is 0: `i_alu_result` is captured into `o_result`, `o_div0` is set to (`o_alu_sel`==11 && `o_alu_b`==0), `o_done[owner]` is set for one cycle, and the FSM returns to IDLE.
- **Requester protocol.**
  - A requester holds `i_req` and keeps its operands stable until it sees its `o_grant`.
  - It should drop `i_req` the cycle after the grant.
  - A request still high when the FSM is back in IDLE counts as a new request.
- **Arithmetic.**
  - The block computes no result itself.
  - `o_result` is whatever the calculator supplies: WIDTH bits, wrapped modulo 2^WIDTH, and 0 for divide-by-zero.
  - `o_div0` is the only arithmetic decision made here.
- **Fairness.** With both requesters permanently requesting, grants strictly alternate 0,1,0,1…

## Timing
- **Reset values.** All outputs are 0. The FSM is in IDLE. `r_last` is 1, so requester 0 has first priority.
- **Latency (SETTLE=1).**
  - Request sampled at edge k: `o_grant` and `o_busy` are high in cycle k+1, and `o_alu_*` are valid from k+1.
  - Capture happens at edge k+1: `o_done` is high and `o_result` is valid in cycle k+2.
- **General latency.**
  - `o_done` arrives SETTLE cycles after `o_grant`.
  - Back-to-back ops give one op per SETTLE+1 cycles, because a request sampled in the `o_done` cycle is granted immediately.
- **Simultaneous events.**
  - A request arriving during EXEC waits; it is never lost as long as it is held high.
  - `o_done` and a new `o_grant` never overlap; the next grant is at least one cycle after `o_done`.
- **Reset mid-EXEC.**
  - The operation is aborted with no `o_done` pulse.
  - All outputs clear and `r_last` returns to 1.
- **SETTLE out of range.** Behaviour is undefined; the verification engineer must flag it in simulation.

## Test plan
- **Single request, SETTLE=1.** After reset, `i_req`=01 with A0=3, B0=4, sel0=00.
  - `o_grant`=01 for one cycle.
  - `o_done`=01 one cycle later, with `o_result`=7 and `o_div0`=0.
  - `o_busy` is high for exactly one cycle.
- **Contention and fairness.** Both requesters hold `i_req`=11 continuously.
  - The grant sequence is 01,10,01,10.
  - Each grant is followed by a `o_done` with the matching owner and result; e.g. A0=9-B0=2 gives 7, and A1=3*B1=5 gives 15.
- **Divide-by-zero and wrap.** Requester 1 issues sel=11, A=9, B=0, then sel=00, A=15, B=1.
  - First op: `o_result`=0, `o_div0`=1.
  - Second op: `o_result`=0, `o_div0`=0.
- **SETTLE=3, operand freeze.** Grant requester 0 with A0=6, B0=2, sel=10, then change A0 to 1 during EXEC.
  - `o_done` arrives 3 cycles after `o_grant` with `o_result`=12.
  - `o_alu_a` stays 6 throughout EXEC.
- **Reset mid-operation.** SETTLE=3; assert `i_reset` one cycle after the grant.
  - No `o_done` pulse for the aborted op.
  - All outputs read 0.
  - A subsequent `i_req`=11 grants requester 0 first.
- **Back-to-back single requester.** Requester 0 holds `i_req` high with SETTLE=1.
  - Grants land every 2 cycles.
  - `o_done` and `o_grant` are never high in the same cycle.
